// File: rtl/crp16_ld_pkg.sv
// Shared definitions for the crp16 load sequencer: data width and FSM state encoding.
package crp16_ld_pkg;

   localparam int unsigned DataW = 16;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRd0  = 2'd1,
      StRd1  = 2'd2,
      StResp = 2'd3
   } ld_state_e;

endpackage

// File: rtl/extend_16.sv
// Widens a val_width-bit value to 16 bits, sign-extending when zero_sign is set.
module extend_16 #(
   parameter int unsigned val_width = 8
) (
   input  logic [val_width-1:0] value,
   input  logic                 zero_sign,
   output logic [15:0]          result
);

   // Replicate the top bit only for signed extension
   always_comb begin
      result = {{(16 - val_width){zero_sign & value[val_width-1]}}, value};
   end

endmodule

// File: rtl/load_ext_ctrl.sv
// crp16 memory-stage load sequencer: word-aligned reads, misaligned word split,
// byte extraction/extension and a valid/ready response to writeback.
module load_ext_ctrl
   import crp16_ld_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TAG_WIDTH      = 3
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [DataW-1:0]     req_addr,
   input  logic                 req_word,
   input  logic                 req_signed,
   input  logic [TAG_WIDTH-1:0] req_tag,
   output logic                 mem_rd,
   output logic [DataW-1:0]     mem_addr,
   input  logic                 mem_ready,
   input  logic [DataW-1:0]     mem_rdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DataW-1:0]     rsp_data,
   output logic [TAG_WIDTH-1:0] rsp_tag,
   output logic                 rsp_err
);

   // Counter only ever holds 0 .. TIMEOUT_CYCLES-1
   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   ld_state_e              state_q, state_d;
   logic [DataW-1:0]       addr_q;
   logic                   word_q;
   logic                   signed_q;
   logic [7:0]             lo_byte_q;
   logic [DataW-1:0]       mem_addr_q;
   logic [CntW-1:0]        cnt_q;
   logic [DataW-1:0]       rsp_data_q;
   logic [TAG_WIDTH-1:0]   rsp_tag_q;
   logic                   rsp_err_q;

   logic                   accept;
   logic                   rd_active;
   logic                   timed_out;
   logic                   split_word;
   logic [7:0]             byte_sel;
   logic [DataW-1:0]       byte_ext;
   logic [DataW-1:0]       merged;

   // Request/read status decode
   always_comb begin
      accept     = req_valid && (state_q == StIdle);
      rd_active  = (state_q == StRd0) || (state_q == StRd1);
      split_word = word_q && addr_q[0];
      // mem_ready in the limit cycle takes priority over the timeout
      timed_out  = (TIMEOUT_CYCLES != 0) && rd_active && !mem_ready &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   end

   // Byte lane select and read-data merge
   always_comb begin
      byte_sel = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
      if (state_q == StRd1) begin
         merged = {mem_rdata[7:0], lo_byte_q};
      end else if (word_q) begin
         merged = mem_rdata;
      end else begin
         merged = byte_ext;
      end
   end

   extend_16 #(
      .val_width (8)
   ) u_extend (
      .value     (byte_sel),
      .zero_sign (signed_q),
      .result    (byte_ext)
   );

   // State register
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept) state_d = StRd0;
         StRd0: begin
            if (mem_ready) state_d = split_word ? StRd1 : StResp;
            else if (timed_out) state_d = StResp;
         end
         StRd1:  if (mem_ready || timed_out) state_d = StResp;
         StResp: if (rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from the registered state
   always_comb begin
      req_ready = (state_q == StIdle);
      mem_rd    = rd_active;
      rsp_valid = (state_q == StResp);
      mem_addr  = mem_addr_q;
      rsp_data  = rsp_data_q;
      rsp_tag   = rsp_tag_q;
      rsp_err   = rsp_err_q;
   end

   // Request capture, read address, timeout counter and response data
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         addr_q     <= '0;
         word_q     <= 1'b0;
         signed_q   <= 1'b0;
         lo_byte_q  <= '0;
         mem_addr_q <= '0;
         cnt_q      <= '0;
         rsp_data_q <= '0;
         rsp_tag_q  <= '0;
         rsp_err_q  <= 1'b0;
      end else if (accept) begin
         addr_q     <= req_addr;
         word_q     <= req_word;
         signed_q   <= req_signed;
         rsp_tag_q  <= req_tag;
         rsp_err_q  <= 1'b0;
         mem_addr_q <= {req_addr[DataW-1:1], 1'b0};
         cnt_q      <= '0;
      end else if (rd_active) begin
         if (mem_ready) begin
            if ((state_q == StRd0) && split_word) begin
               // First half of a misaligned word: odd byte becomes the low byte
               lo_byte_q  <= mem_rdata[15:8];
               mem_addr_q <= mem_addr_q + 16'd2;
               cnt_q      <= '0;
            end else begin
               rsp_data_q <= merged;
            end
         end else if (timed_out) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end
   end

endmodule
